// File: rtl/ctrl_pipe_chain_pkg.sv
// ctrl_pipe_chain_pkg
//   Shared encoding for control-bundle pipeline registers. Every pipeline
//   boundary imports this package, so the bundle layout and the bubble value
//   are the same everywhere in the datapath.
//   Contents:
//     - field positions of the default MEM->WB bundle {mem_to_reg[1:0], reg_write}
//     - BUBBLE_DEFAULT: bundle value with every write disabled
//     - count_ones(): population count used for pipeline occupancy
package ctrl_pipe_chain_pkg;

  localparam int CTRL_W_DEFAULT = 3;
  localparam int MEM_TO_REG_MSB = 2;
  localparam int MEM_TO_REG_LSB = 1;
  localparam int REG_WRITE_BIT  = 0;

  // Upper bound on pipeline depth that count_ones() can handle.
  localparam int MAX_STAGES = 64;

  localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE_DEFAULT = '0;

  typedef struct packed {
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } mem_wb_ctrl_t;

  function automatic int count_ones(input logic [MAX_STAGES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_stage.sv
// ctrl_pipe_stage
//   One {valid, ctrl} register of the control pipeline.
//   Per-edge priority: rst > flush > hold > load.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     flush        turn this stage into a bubble at this edge
//     hold         keep current contents (global stall)
//     load_valid   valid bit of the entry offered by the previous stage/input
//     load_ctrl    control bundle of that entry
//     valid, ctrl  registered contents of this stage
module ctrl_pipe_stage #(
  parameter int                CTRL_W = 3,
  parameter logic [CTRL_W-1:0] BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              load_valid,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl
);

  // An invalid entry always stores BUBBLE, so the ctrl register never holds
  // stale or unknown write enables behind a cleared valid bit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      ctrl  <= BUBBLE;
    end else if (!hold) begin
      valid <= load_valid;
      ctrl  <= load_valid ? load_ctrl : BUBBLE;
    end
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
//   Multi-stage control-signal pipeline register with global stall,
//   per-stage flush, masked output and occupancy count.
//   Ports:
//     clk, rst      clock and synchronous active-high reset
//     stall         hold every stage; in_* is dropped
//     flush[k]      stage k becomes a bubble at this edge
//     in_valid      incoming bundle is a real instruction
//     in_ctrl       incoming control bundle
//     out_valid     valid bit of the last stage
//     out_ctrl      last-stage bundle, BUBBLE when out_valid=0
//     stage_valid   valid bit of every stage
//     occupancy     number of valid stages (0..STAGES)
module ctrl_pipe_chain
  import ctrl_pipe_chain_pkg::*;
#(
  parameter int                CTRL_W = 3,
  parameter int                STAGES = 1,
  parameter logic [CTRL_W-1:0] BUBBLE = {CTRL_W{1'b0}},
  localparam int               OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [STAGES-1:0] stage_valid,
  output logic [OCC_W-1:0]  occupancy
);

  logic [STAGES-1:0] valid_q;
  logic [CTRL_W-1:0] ctrl_q [STAGES];

  // Stage 0 loads from the input, every later stage from its predecessor.
  // A flush on stage k only clears k; stage k's old contents still move on.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      ctrl_pipe_stage #(
        .CTRL_W (CTRL_W),
        .BUBBLE (BUBBLE)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush[k]),
        .hold       (stall),
        .load_valid (in_valid),
        .load_ctrl  (in_ctrl),
        .valid      (valid_q[k]),
        .ctrl       (ctrl_q[k])
      );
    end else begin : g_next
      ctrl_pipe_stage #(
        .CTRL_W (CTRL_W),
        .BUBBLE (BUBBLE)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush[k]),
        .hold       (stall),
        .load_valid (valid_q[k-1]),
        .load_ctrl  (ctrl_q[k-1]),
        .valid      (valid_q[k]),
        .ctrl       (ctrl_q[k])
      );
    end
  end

  // Masking here is a second line of defence: no write enable can leave
  // the block from a slot whose valid bit is clear.
  always_comb begin
    out_valid   = valid_q[STAGES-1];
    out_ctrl    = valid_q[STAGES-1] ? ctrl_q[STAGES-1] : BUBBLE;
    stage_valid = valid_q;
    occupancy   = OCC_W'(count_ones(MAX_STAGES'(valid_q)));
  end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain
//   Bench for ctrl_pipe_chain with two instances: a 3-stage, 3-bit bundle
//   with zero bubble, and a 1-stage, 8-bit bundle with bubble 8'hA5.
//   Stimulus pushes the expected exit order into per-instance queues; a
//   monitor per instance pops on every new valid output.
module tb_ctrl_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_stall;
  logic [2:0] a_flush;
  logic       a_in_valid;
  logic [2:0] a_in_ctrl;
  logic       a_out_valid;
  logic [2:0] a_out_ctrl;
  logic [2:0] a_stage_valid;
  logic [1:0] a_occupancy;

  logic       b_stall;
  logic [0:0] b_flush;
  logic       b_in_valid;
  logic [7:0] b_in_ctrl;
  logic       b_out_valid;
  logic [7:0] b_out_ctrl;
  logic [0:0] b_stage_valid;
  logic [0:0] b_occupancy;

  ctrl_pipe_chain #(
    .CTRL_W (3),
    .STAGES (3),
    .BUBBLE (3'b000)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .stall       (a_stall),
    .flush       (a_flush),
    .in_valid    (a_in_valid),
    .in_ctrl     (a_in_ctrl),
    .out_valid   (a_out_valid),
    .out_ctrl    (a_out_ctrl),
    .stage_valid (a_stage_valid),
    .occupancy   (a_occupancy)
  );

  ctrl_pipe_chain #(
    .CTRL_W (8),
    .STAGES (1),
    .BUBBLE (8'hA5)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .stall       (b_stall),
    .flush       (b_flush),
    .in_valid    (b_in_valid),
    .in_ctrl     (b_in_ctrl),
    .out_valid   (b_out_valid),
    .out_ctrl    (b_out_ctrl),
    .stage_valid (b_stage_valid),
    .occupancy   (b_occupancy)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [2:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [2:0] last_a = '0;
  logic [7:0] last_b = '0;
  logic       mon_en = 1'b0;
  logic       a_stall_at_edge = 1'b0;
  logic       b_stall_at_edge = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic s, input logic [2:0] f);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_stall    = s;
    a_flush    = f;
    tick();
  endtask

  task automatic applyStimulusB(input logic v, input logic [7:0] c, input logic s, input logic f);
    b_in_valid = v;
    b_in_ctrl  = c;
    b_stall    = s;
    b_flush    = f;
    tick();
  endtask

  // Remember whether each edge was a stall edge, so the monitors can tell
  // a newly arrived output from one that is merely being held.
  always @(posedge clk) begin
    a_stall_at_edge = a_stall;
    b_stall_at_edge = b_stall;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_out_valid && !a_stall_at_edge) begin
        if (exp_a.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL monA_unexpected: got out_ctrl=%b, required no valid output", a_out_ctrl);
        end else begin
          last_a = exp_a.pop_front();
          checkOutput("monA_ctrl", 32'(a_out_ctrl), 32'(last_a));
        end
      end else if (a_out_valid) begin
        checkOutput("monA_hold", 32'(a_out_ctrl), 32'(last_a));
      end else begin
        checkOutput("monA_bubble", 32'(a_out_ctrl), 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_out_valid && !b_stall_at_edge) begin
        if (exp_b.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL monB_unexpected: got out_ctrl=%h, required no valid output", b_out_ctrl);
        end else begin
          last_b = exp_b.pop_front();
          checkOutput("monB_ctrl", 32'(b_out_ctrl), 32'(last_b));
        end
      end else if (b_out_valid) begin
        checkOutput("monB_hold", 32'(b_out_ctrl), 32'(last_b));
      end else begin
        checkOutput("monB_bubble", 32'(b_out_ctrl), 32'hA5);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_stall = 1'b0; a_flush = '0; a_in_valid = 1'b0; a_in_ctrl = '0;
    b_stall = 1'b0; b_flush = '0; b_in_valid = 1'b0; b_in_ctrl = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of both instances
    checkOutput("rstA_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("rstA_out_ctrl", 32'(a_out_ctrl), 32'h0);
    checkOutput("rstA_stage_valid", 32'(a_stage_valid), 32'h0);
    checkOutput("rstA_occupancy", 32'(a_occupancy), 32'h0);
    checkOutput("rstB_out_valid", 32'(b_out_valid), 32'h0);
    checkOutput("rstB_out_ctrl", 32'(b_out_ctrl), 32'hA5);
    checkOutput("rstB_stage_valid", 32'(b_stage_valid), 32'h0);
    checkOutput("rstB_occupancy", 32'(b_occupancy), 32'h0);
    mon_en = 1'b1;

    // A1: single entry, latency three edges
    exp_a.push_back(3'b101);
    applyStimulus(1'b1, 3'b101, 1'b0, 3'b000);
    checkOutput("A1_sv_e1", 32'(a_stage_valid), 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);
    checkOutput("A1_out_valid_e2", 32'(a_out_valid), 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);
    checkOutput("A1_out_valid_e3", 32'(a_out_valid), 32'h1);
    checkOutput("A1_out_ctrl_e3", 32'(a_out_ctrl), 32'h5);
    applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);

    // A2: stream with a stall on the third edge
    exp_a.push_back(3'b101);
    exp_a.push_back(3'b011);
    exp_a.push_back(3'b110);
    applyStimulus(1'b1, 3'b101, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b011, 1'b0, 3'b000);
    checkOutput("A2_sv_e2", 32'(a_stage_valid), 32'h3);
    applyStimulus(1'b1, 3'b110, 1'b1, 3'b000);
    checkOutput("A2_sv_stall", 32'(a_stage_valid), 32'h3);
    checkOutput("A2_occ_stall", 32'(a_occupancy), 32'h2);
    applyStimulus(1'b1, 3'b110, 1'b0, 3'b000);
    checkOutput("A2_sv_full", 32'(a_stage_valid), 32'h7);
    checkOutput("A2_occ_full", 32'(a_occupancy), 32'h3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);
    checkOutput("A2_occ_drained", 32'(a_occupancy), 32'h0);

    // A3: full pipe, flush stage 1 kills the entry moving into it (100)
    exp_a.push_back(3'b001);
    exp_a.push_back(3'b010);
    applyStimulus(1'b1, 3'b001, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b010, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b100, 1'b0, 3'b000);
    checkOutput("A3_sv_full", 32'(a_stage_valid), 32'h7);
    exp_a.push_back(3'b110);
    applyStimulus(1'b1, 3'b110, 1'b0, 3'b010);
    checkOutput("A3_sv_flush", 32'(a_stage_valid), 32'h5);
    checkOutput("A3_occ_flush", 32'(a_occupancy), 32'h2);
    checkOutput("A3_out_ctrl_flush", 32'(a_out_ctrl), 32'h2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);

    // A4: stall together with flush of the last stage
    exp_a.push_back(3'b011);
    exp_a.push_back(3'b101);
    exp_a.push_back(3'b111);
    applyStimulus(1'b1, 3'b011, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b101, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b111, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000, 1'b1, 3'b100);
    checkOutput("A4_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("A4_out_ctrl", 32'(a_out_ctrl), 32'h0);
    checkOutput("A4_sv", 32'(a_stage_valid), 32'h3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);

    // A5: invalid input with all-ones ctrl must exit as a bubble
    exp_a.push_back(3'b001);
    exp_a.push_back(3'b010);
    applyStimulus(1'b1, 3'b001, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b111, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b010, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);
    checkOutput("A5_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("A5_out_ctrl", 32'(a_out_ctrl), 32'h0);
    checkOutput("A5_sv", 32'(a_stage_valid), 32'h2);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);

    // A6: reset with the pipe full and stalled discards everything
    exp_a.push_back(3'b111);
    applyStimulus(1'b1, 3'b111, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b110, 1'b0, 3'b000);
    applyStimulus(1'b1, 3'b101, 1'b0, 3'b000);
    rst = 1'b1;
    applyStimulus(1'b1, 3'b011, 1'b1, 3'b000);
    rst = 1'b0;
    checkOutput("A6_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("A6_out_ctrl", 32'(a_out_ctrl), 32'h0);
    checkOutput("A6_sv", 32'(a_stage_valid), 32'h0);
    checkOutput("A6_occ", 32'(a_occupancy), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'b000, 1'b0, 3'b000);

    // B1: single stage, latency one edge, bubble value A5
    exp_b.push_back(8'h3C);
    applyStimulusB(1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("B1_out_valid", 32'(b_out_valid), 32'h1);
    checkOutput("B1_out_ctrl", 32'(b_out_ctrl), 32'h3C);
    checkOutput("B1_occ", 32'(b_occupancy), 32'h1);
    applyStimulusB(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("B1_out_ctrl_idle", 32'(b_out_ctrl), 32'hA5);

    // B2: stream with a stall on the third edge
    exp_b.push_back(8'h11);
    exp_b.push_back(8'h22);
    exp_b.push_back(8'h33);
    applyStimulusB(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulusB(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulusB(1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("B2_out_ctrl_stall", 32'(b_out_ctrl), 32'h22);
    checkOutput("B2_occ_stall", 32'(b_occupancy), 32'h1);
    applyStimulusB(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("B2_out_ctrl", 32'(b_out_ctrl), 32'h33);
    applyStimulusB(1'b0, 8'h00, 1'b0, 1'b0);

    // B3: flush kills the incoming bundle; invalid input shows bubble
    exp_b.push_back(8'h44);
    applyStimulusB(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulusB(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("B3_out_valid", 32'(b_out_valid), 32'h0);
    checkOutput("B3_out_ctrl", 32'(b_out_ctrl), 32'hA5);
    checkOutput("B3_sv", 32'(b_stage_valid), 32'h0);
    applyStimulusB(1'b0, 8'hFF, 1'b0, 1'b0);
    checkOutput("B3_invalid_ctrl", 32'(b_out_ctrl), 32'hA5);

    // B4: reset overrides stall
    exp_b.push_back(8'h66);
    applyStimulusB(1'b1, 8'h66, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulusB(1'b1, 8'h77, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("B4_out_valid", 32'(b_out_valid), 32'h0);
    checkOutput("B4_out_ctrl", 32'(b_out_ctrl), 32'hA5);
    applyStimulusB(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulusB(1'b0, 8'h00, 1'b0, 1'b0);

    checkOutput("A_queue_empty", 32'(exp_a.size()), 32'h0);
    checkOutput("B_queue_empty", 32'(exp_b.size()), 32'h0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
